rvr32_mt_pcunit: RTL

Multi-hart program-counter unit for the barrel-threaded Rover32 variant. It holds NHART independent PCs and selects one eligible hart per cycle, round-robin, for fetch. It applies sequential, branch and jump next-PC updates as instructions of each hart retire. Misaligned targets are trapped instead of written. It sits between the fetch stage (consumer of fetch_pc) and execute/writeback (producer of updates).

---
 rtl/rvr32_pkg.sv | 21 ++
 rtl/rvr32_rr_arbiter.sv | 52 +++++
 rtl/rvr32_mt_pcunit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rvr32_pkg.sv
// Shared constants and helpers for the Rover32 multi-hart PC unit.
//   hart_w()     : index width for a given hart count
//   align_mask() : low-bit mask of target bits that must be zero
//   PC_INC       : sequential next-PC increment
package rvr32_pkg;

    localparam int unsigned PC_INC = 4;

    // Bit0 is always even after target formation, so only bit1 can trap.
    localparam logic [1:0] ALIGN_MASK_W = 2'b10;
    localparam logic [1:0] ALIGN_MASK_H = 2'b00;

    function automatic int unsigned hart_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [1:0] align_mask(input int unsigned align_c);
        return (align_c == 0) ? ALIGN_MASK_W : ALIGN_MASK_H;
    endfunction

endpackage

// File: rtl/rvr32_rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after the last
// granted index, circularly. Pointer advances only on a non-held grant.
//   clk, rst_n   : clock, async active-low reset (pointer -> N-1)
//   hold         : suppress grant and freeze pointer
//   req          : per-index request
//   gnt_vld_c    : a grant is issued this cycle (combinational)
//   gnt_idx_c    : granted index (combinational)
module rvr32_rr_arbiter
    import rvr32_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned W = hart_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic [N-1:0] req,
    output logic         gnt_vld_c,
    output logic [W-1:0] gnt_idx_c
);

    logic [W-1:0] ptr;
    logic [W-1:0] cand;

    // Circular search starting one past the pointer; N is a power of two so
    // the index wraps by truncation.
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_idx_c = ptr;
        cand      = ptr;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = ptr + W'(k);
            if (!gnt_vld_c && req[cand]) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = cand;
            end
        end
        if (hold) begin
            gnt_vld_c = 1'b0;
        end
    end

    // Pointer register; reset so index 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= W'(N - 1);
        end else if (gnt_vld_c) begin
            ptr <= gnt_idx_c;
        end
    end

endmodule

// File: rtl/rvr32_mt_pcunit.sv
// Multi-hart PC unit: NHART PCs, round-robin fetch selection of eligible
// harts (enabled and not in flight), retire-time next-PC update with
// misaligned-target trapping.
//   clk, rst_n                        : clock, async active-low reset
//   stall                             : freeze fetch selection/outputs
//   hart_en                           : per-hart fetch enable
//   fetch_vld/fetch_hart/fetch_pc     : registered fetch grant
//   upd_vld/upd_hart/brj/bjimm/jmp/jdata : retire update
//   misalign/misalign_hart/misalign_addr : registered trap pulse + info
//   pc_rd_hart/pc_rd                  : combinational debug PC read
module rvr32_mt_pcunit
    import rvr32_pkg::*;
#(
    parameter int unsigned   XLEN     = 32,
    parameter int unsigned   NHART    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned   ALIGN_C  = 0,
    localparam int unsigned  HW       = hart_w(NHART)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [NHART-1:0] hart_en,
    output logic             fetch_vld,
    output logic [HW-1:0]    fetch_hart,
    output logic [XLEN-1:0]  fetch_pc,
    input  logic             upd_vld,
    input  logic [HW-1:0]    upd_hart,
    input  logic             brj,
    input  logic [XLEN-1:0]  bjimm,
    input  logic             jmp,
    input  logic [XLEN-1:0]  jdata,
    output logic             misalign,
    output logic [HW-1:0]    misalign_hart,
    output logic [XLEN-1:0]  misalign_addr,
    input  logic [HW-1:0]    pc_rd_hart,
    output logic [XLEN-1:0]  pc_rd
);

    logic [XLEN-1:0]  pc [NHART];
    logic [NHART-1:0] inflight;
    logic [NHART-1:0] elig_c;
    logic             gnt_vld_c;
    logic [HW-1:0]    gnt_idx_c;
    logic             upd_ok_c;
    logic [XLEN-1:0]  target_c;
    logic             bad_c;
    logic [NHART-1:0] set_c;
    logic [NHART-1:0] clr_c;

    assign elig_c = hart_en & ~inflight;

    rvr32_rr_arbiter #(
        .N (NHART)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (stall),
        .req       (elig_c),
        .gnt_vld_c (gnt_vld_c),
        .gnt_idx_c (gnt_idx_c)
    );

    // Next-PC target formation; JALR has priority and is forced even.
    always_comb begin
        upd_ok_c = upd_vld & inflight[upd_hart];
        target_c = pc[upd_hart] + XLEN'(PC_INC);
        if (jmp) begin
            target_c = jdata & ~XLEN'(1);
        end else if (brj) begin
            target_c = pc[upd_hart] + bjimm;
        end
        bad_c = |(target_c[1:0] & align_mask(ALIGN_C));
    end

    // In-flight set on grant, clear on accepted update (always distinct harts).
    always_comb begin
        set_c = '0;
        clr_c = '0;
        if (gnt_vld_c) begin
            set_c = NHART'(1) << gnt_idx_c;
        end
        if (upd_ok_c) begin
            clr_c = NHART'(1) << upd_hart;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            inflight <= (inflight | set_c) & ~clr_c;
        end
    end

    // PC file: written only by an accepted, aligned update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NHART; i++) begin
                pc[i] <= RESET_PC;
            end
        end else if (upd_ok_c && !bad_c) begin
            pc[upd_hart] <= target_c;
        end
    end

    // Fetch output register; hart/pc hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_vld  <= 1'b0;
            fetch_hart <= '0;
            fetch_pc   <= RESET_PC;
        end else if (!stall) begin
            fetch_vld <= gnt_vld_c;
            if (gnt_vld_c) begin
                fetch_hart <= gnt_idx_c;
                fetch_pc   <= pc[gnt_idx_c];
            end
        end
    end

    // Trap register: one-cycle pulse, info held until the next trap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign      <= 1'b0;
            misalign_hart <= '0;
            misalign_addr <= '0;
        end else begin
            misalign <= upd_ok_c & bad_c;
            if (upd_ok_c && bad_c) begin
                misalign_hart <= upd_hart;
                misalign_addr <= target_c;
            end
        end
    end

    assign pc_rd = pc[pc_rd_hart];

endmodule
